cbd_sample_ctrl: RTL and testbench
==================================

Name: cbd_sample_ctrl

Overview:
- Sequencer that turns a PRF byte stream into one centered-binomial (eta=2) polynomial of N coefficients for Kyber-768 key generation and encryption.
- Accepts 64*ETA = 128 bytes through a valid/ready handshake.
- Splits each byte into two 4-bit groups and computes one coefficient per group.
- Streams coefficients with an index to the NTT/polynomial buffer, then pulses done.

Parameters:
- N, 256, coefficients per polynomial.
- Q, 3329, Kyber modulus; used only when the optional feature is compiled in.
- COEF_W, 12, output coefficient width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a polynomial; ignored unless the FSM is in IDLE.
- flush  in  1  synchronous abort; returns the FSM to IDLE next cycle; highest priority after rst.
- in_valid  in  1  PRF byte valid.
- in_byte  in  8  PRF byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_valid  out  1  coefficient valid.
- out_coef  out  COEF_W  coefficient value.
- out_idx  out  8  coefficient index, 0..N-1.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the polynomial completes.

Behaviour:
- Reset: state IDLE; byte register, byte counter and coefficient counter 0. All outputs 0: in_ready, out_valid, out_coef, out_idx, busy, done.
- States: IDLE, FETCH, EMIT_LO, EMIT_HI, FIN.
- IDLE -> FETCH on start.
- FETCH: in_ready=1. On handshake, latch in_byte and go to EMIT_LO.
- EMIT_LO: out_valid=1, coefficient from bits [3:0]. On out_ready go to EMIT_HI.
- EMIT_HI: out_valid=1, coefficient from bits [7:4]. On out_ready:
  - go to FIN if out_idx==N-1;
  - otherwise go to FETCH.
- FIN: done=1 for one cycle, then IDLE.
- Coefficient for group bits g[3:0]: (g0+g1) - (g2+g3), range -2..+2.
- Without the optional feature, out_coef is that value sign-extended to COEF_W bits, two's complement.
- out_idx increments by 1 on each output handshake. It is 0 for the first coefficient of each polynomial and resets to 0 on start.
- out_coef and out_idx must stay stable while out_valid && !out_ready; the block never drops or reorders coefficients.
- Throughput: one byte per 3 cycles when there is no backpressure. First out_valid appears 1 cycle after the first byte handshake.
- Exactly N/2 = 128 byte handshakes per polynomial. in_ready is never 1 outside FETCH.
- start while busy: ignored, with no effect on counters.
- flush while busy: next cycle returns to IDLE with counters cleared. out_valid and in_ready drop immediately (combinational from state), and done is not pulsed.
- flush and start in the same cycle while in IDLE: flush wins and the block stays IDLE.
- rst mid-operation: returns to the reset state asynchronously.

Optional Feature:
- Macro CBD_MODQ_EN.
- When defined: out_coef is reduced into [0, Q): a negative value v is output as Q+v. Example: -2 -> 3327, -1 -> 3328.
- When undefined: out_coef is two's complement sign-extended (-2 -> 12'hFFE).
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package kyber_pkg holds:
  - constants KYBER_N=256, KYBER_Q=3329, KYBER_ETA=2;
  - typedef coef_t (logic [11:0]);
  - the cbd state enum.
- One natural sub-module, cbd_nibble, computes one coefficient from 4 bits. It is purely combinational and instantiated once, fed by a mux selecting the low or high nibble on state.

Test Plan:
- start; bytes 0x00, 0x03, 0xC0, 0x5A with out_ready=1 -> coefficients 0, 0, +2, 0, 0, -2, 0, 0 at idx 0..7. The -2 is 12'hFFE, or 3327 with CBD_MODQ_EN.
- Full polynomial of 128 random bytes -> 256 coefficients matching a software CBD model, last out_idx=255, a single done pulse, busy low afterwards.
- Hold out_ready=0 for 5 cycles during EMIT_HI -> out_coef and out_idx stable, in_ready=0, no byte consumed.
- Assert flush after 40 coefficients -> IDLE next cycle, no done. A following start restarts at idx 0.
- start pulsed again at idx 100 -> ignored; sequence continues to idx 255.
- Assert rst during EMIT_LO -> all outputs 0 immediately. After release, start and byte 0x0F produce coefficients 0, 0.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and the CBD sequencer state encoding.
package kyber_pkg;

  localparam int KYBER_N   = 256;
  localparam int KYBER_Q   = 3329;
  localparam int KYBER_ETA = 2;

  typedef logic [11:0] coef_t;

  typedef enum logic [2:0] {
    CBD_IDLE    = 3'd0,
    CBD_FETCH   = 3'd1,
    CBD_EMIT_LO = 3'd2,
    CBD_EMIT_HI = 3'd3,
    CBD_FIN     = 3'd4
  } cbd_state_e;

endpackage

// File: rtl/cbd_nibble.sv
// Centered-binomial (eta=2) coefficient from one 4-bit group:
// (g0+g1) - (g2+g3), range -2..+2.
// Optional build macro CBD_MODQ_EN: output is reduced into [0, Q)
// instead of being two's complement sign-extended.
module cbd_nibble
  import kyber_pkg::*;
(
  input  logic [3:0] g,
  output coef_t      coef
);

  logic [2:0] pos_sum;
  logic [2:0] neg_sum;
  logic [2:0] diff;
  coef_t      sext;

  // Small signed difference, widened to the coefficient width.
  always_comb begin
    pos_sum = {2'b00, g[0]} + {2'b00, g[1]};
    neg_sum = {2'b00, g[2]} + {2'b00, g[3]};
    diff    = pos_sum - neg_sum;
    sext    = {{9{diff[2]}}, diff};
`ifdef CBD_MODQ_EN
    // Negative v becomes Q+v; adding Q to the 12-bit two's complement
    // pattern gives exactly that modulo 4096.
    coef    = sext[11] ? (sext + coef_t'(KYBER_Q)) : sext;
`else
    coef    = sext;
`endif
  end

endmodule

// File: rtl/cbd_sample_ctrl.sv
// Sequencer turning a PRF byte stream into one CBD(eta=2) polynomial.
// Each accepted byte yields two coefficients: low nibble first, then high.
// Optional build macro CBD_MODQ_EN selects mod-Q coefficient encoding
// (see cbd_nibble); latency and handshakes are the same in both builds.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in FETCH; out_valid only in EMIT_LO/EMIT_HI and
// both are decoded from the state register alone. While out_valid is high
// and out_ready low, out_coef and out_idx hold their values.
module cbd_sample_ctrl
  import kyber_pkg::*;
#(
  parameter int N      = KYBER_N,
  parameter int COEF_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              out_valid,
  output logic [COEF_W-1:0] out_coef,
  output logic [7:0]        out_idx,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output cbd_state_e        dbg_state,
  output logic [7:0]        dbg_byte_cnt
);

  localparam logic [7:0] LAST_IDX = 8'(N - 1);

  cbd_state_e state_q;
  cbd_state_e state_d;
  logic [7:0] byte_q;
  logic [7:0] byte_cnt_q;
  logic [7:0] idx_q;
  logic [3:0] nib;
  coef_t      nib_coef;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CBD_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and handshake/status outputs; flush overrides all.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state_q != CBD_IDLE);
    case (state_q)
      CBD_IDLE: begin
        if (start) state_d = CBD_FETCH;
      end
      CBD_FETCH: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CBD_EMIT_LO;
      end
      CBD_EMIT_LO: begin
        out_valid = 1'b1;
        if (out_ready) state_d = CBD_EMIT_HI;
      end
      CBD_EMIT_HI: begin
        out_valid = 1'b1;
        if (out_ready) state_d = (idx_q == LAST_IDX) ? CBD_FIN : CBD_FETCH;
      end
      CBD_FIN: begin
        done    = 1'b1;
        state_d = CBD_IDLE;
      end
      default: state_d = CBD_IDLE;
    endcase
    if (flush) state_d = CBD_IDLE;
  end

  // Byte register and counters; start is honoured only from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q     <= '0;
      byte_cnt_q <= '0;
      idx_q      <= '0;
    end else if (flush) begin
      byte_q     <= '0;
      byte_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      if (state_q == CBD_IDLE && start) begin
        byte_cnt_q <= '0;
        idx_q      <= '0;
      end
      if (in_ready && in_valid) begin
        byte_q     <= in_byte;
        byte_cnt_q <= byte_cnt_q + 8'd1;
      end
      if (out_valid && out_ready) idx_q <= idx_q + 8'd1;
    end
  end

  // Nibble select: high half only while emitting the second coefficient.
  always_comb begin
    nib = (state_q == CBD_EMIT_HI) ? byte_q[7:4] : byte_q[3:0];
  end

  cbd_nibble u_nibble (
    .g    (nib),
    .coef (nib_coef)
  );

  assign out_coef     = out_valid ? COEF_W'(nib_coef) : '0;
  assign out_idx      = idx_q;
  assign dbg_state    = state_q;
  assign dbg_byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_cbd_sample_ctrl.sv
// Bench for cbd_sample_ctrl: byte feeder, negedge monitor with an expected
// queue built from a plain CBD model, directed scenarios, final report.
module tb_cbd_sample_ctrl;
  import kyber_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_coef;
  logic [7:0]  out_idx;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
  cbd_state_e  dbg_state;
  logic [7:0]  dbg_byte_cnt;

  cbd_sample_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_coef     (out_coef),
    .out_idx      (out_idx),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state),
    .dbg_byte_cnt (dbg_byte_cnt)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int start_cyc = 0;
  int last_done_cyc = 0;
  int done_cnt = 0;
  logic hs_pending = 1'b0;
  logic [7:0] exp_next_idx = 8'd0;

  logic [7:0]  src_q[$];      // bytes still to be offered
  logic [19:0] exp_q[$];      // {idx, coef} expected on the output
  logic [11:0] got_coef[$];   // accepted coefficients
  logic [7:0]  got_idx[$];    // their indices

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CBD(eta=2) of a 4-bit group, encoded as the block should present it.
  function automatic logic [11:0] model_coef(input logic [3:0] g);
    int v;
    v = int'(g[0]) + int'(g[1]) - int'(g[2]) - int'(g[3]);
`ifdef CBD_MODQ_EN
    if (v < 0) v = v + 3329;
`endif
    return 12'(v);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // ---------------- byte feeder ----------------
  initial begin
    in_valid = 1'b0;
    in_byte  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (hs_pending && src_q.size() > 0) void'(src_q.pop_front());
      in_valid = (src_q.size() > 0);
      in_byte  = in_valid ? src_q[0] : 8'h00;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (rst) begin
      hs_pending = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {out_idx, out_coef}, 32'hFFFFFFFF);
        end else begin
          chk("coef_idx", {12'h0, out_idx, out_coef}, {12'h0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
        if (out_ready) begin
          got_coef.push_back(out_coef);
          got_idx.push_back(out_idx);
        end
      end
      chk("ready_valid_excl", {31'h0, in_ready & out_valid}, 32'h0);
      hs_pending = in_valid && in_ready;
      if (hs_pending) begin
        exp_q.push_back({exp_next_idx, model_coef(in_byte[3:0])});
        exp_q.push_back({exp_next_idx + 8'd1, model_coef(in_byte[7:4])});
        exp_next_idx = exp_next_idx + 8'd2;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc_cnt;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    exp_next_idx = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc_cnt;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    src_q.delete();
  endtask

  task automatic wait_got(input int n, input int limit);
    int k = 0;
    while (got_coef.size() < n && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_got", {31'h0, got_coef.size() >= n}, 32'h1);
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_done", {31'h0, done_cnt != d0}, 32'h1);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- directed scenarios ----------------
  logic [11:0] lit[8];
  logic [11:0] neg2;
  int base;
  int d_before;
  int n0;
  logic [7:0] b0;

  initial begin
`ifdef CBD_MODQ_EN
    neg2 = 12'd3327;
`else
    neg2 = 12'hFFE;
`endif
    lit = '{12'd0, 12'd0, 12'd2, 12'd0, 12'd0, neg2, 12'd0, 12'd0};

    // Reset state
    @(negedge clk);
    chk("rst_in_ready",  {31'h0, in_ready},  32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_coef",  {20'h0, out_coef},  32'h0);
    chk("rst_out_idx",   {24'h0, out_idx},   32'h0);
    chk("rst_busy",      {31'h0, busy},      32'h0);
    chk("rst_done",      {31'h0, done},      32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Known bytes -> hand-computed coefficients
    src_q = '{8'h00, 8'h03, 8'hC0, 8'h5A};
    base = got_coef.size();
    do_start();
    wait_got(base + 8, 100);
    for (int i = 0; i < 8; i++) begin
      if (got_coef.size() > base + i) begin
        chk($sformatf("lit_coef%0d", i), {20'h0, got_coef[base + i]}, {20'h0, lit[i]});
        chk($sformatf("lit_idx%0d", i),  {24'h0, got_idx[base + i]},  i);
      end
    end
    do_flush();

    // Full polynomial, no backpressure
    fill_random(128);
    base = got_coef.size();
    d_before = done_cnt;
    do_start();
    wait_done(1000);
    chk("full_latency", last_done_cyc - start_cyc, 32'd384);
    chk("full_count", got_coef.size() - base, 32'd256);
    if (got_idx.size() > 0) chk("full_last_idx", {24'h0, got_idx[$]}, 32'd255);
    repeat (3) @(negedge clk);
    chk("full_single_done", done_cnt - d_before, 32'd1);
    chk("full_busy_after", {31'h0, busy}, 32'h0);
    chk("full_bytes", {24'h0, dbg_byte_cnt}, 32'd128);
    chk("full_exp_empty", exp_q.size(), 32'd0);

    // Backpressure during EMIT_HI
    src_q = '{8'hC3, 8'h0F, 8'h96, 8'h21};
    b0 = 8'hC3;
    base = got_coef.size();
    do_start();
    wait_got(base + 1, 50);
    out_ready = 1'b0;
    n0 = src_q.size();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid",    {31'h0, out_valid}, 32'h1);
      chk("bp_in_ready", {31'h0, in_ready},  32'h0);
      chk("bp_idx",      {24'h0, out_idx},   32'd1);
      chk("bp_coef",     {20'h0, out_coef},  {20'h0, model_coef(b0[7:4])});
      chk("bp_no_byte",  src_q.size(),       n0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_got(base + 8, 100);
    if (got_idx.size() >= base + 8) chk("bp_idx7", {24'h0, got_idx[base + 7]}, 32'd7);
    do_flush();

    // Flush after 40 coefficients, then restart
    fill_random(128);
    d_before = done_cnt;
    base = got_coef.size();
    do_start();
    wait_got(base + 40, 500);
    do_flush();
    chk("fl_busy",      {31'h0, busy},      32'h0);
    chk("fl_out_valid", {31'h0, out_valid}, 32'h0);
    chk("fl_in_ready",  {31'h0, in_ready},  32'h0);
    chk("fl_idx",       {24'h0, out_idx},   32'h0);
    chk("fl_bytes",     {24'h0, dbg_byte_cnt}, 32'h0);
    repeat (5) @(negedge clk);
    chk("fl_no_done", done_cnt - d_before, 32'd0);
    src_q = '{8'h5A, 8'h33};
    base = got_coef.size();
    do_start();
    wait_got(base + 4, 50);
    if (got_idx.size() >= base + 4) begin
      chk("restart_idx0", {24'h0, got_idx[base]},     32'd0);
      chk("restart_idx3", {24'h0, got_idx[base + 3]}, 32'd3);
    end
    do_flush();

    // start while busy at idx 100 is ignored
    fill_random(128);
    d_before = done_cnt;
    base = got_coef.size();
    do_start();
    wait_got(base + 100, 500);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1000);
    chk("sb_count", got_coef.size() - base, 32'd256);
    if (got_idx.size() > 0) chk("sb_last_idx", {24'h0, got_idx[$]}, 32'd255);
    repeat (3) @(negedge clk);
    chk("sb_single_done", done_cnt - d_before, 32'd1);
    chk("sb_busy_after", {31'h0, busy}, 32'h0);

    // Reset during EMIT_LO
    src_q = '{8'hFF, 8'h12};
    do_start();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("ar_in_ready",  {31'h0, in_ready},  32'h0);
    chk("ar_out_valid", {31'h0, out_valid}, 32'h0);
    chk("ar_out_coef",  {20'h0, out_coef},  32'h0);
    chk("ar_out_idx",   {24'h0, out_idx},   32'h0);
    chk("ar_busy",      {31'h0, busy},      32'h0);
    chk("ar_done",      {31'h0, done},      32'h0);
    exp_q.delete();
    src_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    src_q = '{8'h0F};
    base = got_coef.size();
    do_start();
    wait_got(base + 2, 50);
    if (got_coef.size() >= base + 2) begin
      chk("ar_coef0", {20'h0, got_coef[base]},     32'h0);
      chk("ar_coef1", {20'h0, got_coef[base + 1]}, 32'h0);
      chk("ar_idx1",  {24'h0, got_idx[base + 1]},  32'd1);
    end
    do_flush();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
